ram_sdp_be: RTL and testbench

Parametrised simple-dual-port synchronous RAM with per-byte write enables, configurable read latency, selectable read-during-write behaviour and a built-in clear engine that zeroes the whole array after reset or on request. It is the general-purpose on-chip storage for the design and replaces the fixed 16×8 single-port RAM. It has independent write and read ports, so one write and one read complete every cycle.

---
 rtl/ram_sdp_be.sv | 118 +++++++++++
 tb/tb_ram_sdp_be.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write and a zeroing clear engine.
module ram_sdp_be #(
  parameter int DATA_W   = 8,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);
  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  assign wr_acc = ready & wr_en;
  assign rd_acc = ready & rd_en;

  always_comb begin
    wr_word = mem[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        wr_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Write-first bypass returns the merged word, not raw wr_data
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && wr_acc && wr_addr == rd_addr) begin
      rd_word = wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] p_data;
    logic              p_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_data   <= '0;
        p_valid  <= 1'b0;
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        p_valid  <= rd_acc;
        rd_valid <= p_valid;
        if (rd_acc) p_data <= rd_word;
        if (p_valid) rd_data <= p_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= rd_word;
      end
    end
  end
endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: two instances (RD_LAT=1/read-old
// and RD_LAT=2/write-first) share one stimulus stream.
module tb_ram_sdp_be;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        ready0, ready1, valid0, valid1;
  logic [15:0] data0, data1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_sdp_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data0), .rd_valid(valid0)
  );

  ram_sdp_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data1), .rd_valid(valid1)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, return #1 after the posedge
  task automatic cyc(input logic we, input logic [3:0] wa, input logic [1:0] be,
                     input logic [15:0] wd, input logic re, input logic [3:0] ra,
                     input logic cr);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clear_req = cr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [15:0] e0, input logic [15:0] e1);
    cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, a, 1'b0);
    chk("rd0_valid", {15'd0, valid0}, 16'd1);
    chk("rd0_data", data0, e0);
    chk("rd1_early", {15'd0, valid1}, 16'd0);
    idle();
    chk("rd0_pulse", {15'd0, valid0}, 16'd0);
    chk("rd1_valid", {15'd0, valid1}, 16'd1);
    chk("rd1_data", data1, e1);
  endtask

  // counts edges until ready; both instances must rise on edge 16
  task automatic wait_ready(input string name);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_ready0"}, {15'd0, ready0}, (i == 16) ? 16'd1 : 16'd0);
      chk({name, "_ready1"}, {15'd0, ready1}, (i == 16) ? 16'd1 : 16'd0);
      chk({name, "_novalid"}, {14'd0, valid0, valid1}, 16'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 2,  2'b01, 16'h00AA, 0, 0, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0,  2'b00, 16'h0000, 1, 2, 16'h00AA, 16'h00AA};
    vecs[2]  = '{1, 15, 2'b11, 16'h005C, 0, 0, 16'h0000, 16'h0000};
    vecs[3]  = '{0, 0,  2'b00, 16'h0000, 1, 15, 16'h005C, 16'h005C};
    vecs[4]  = '{1, 7,  2'b11, 16'h1234, 0, 0, 16'h0000, 16'h0000};
    vecs[5]  = '{1, 7,  2'b10, 16'hABCD, 0, 0, 16'h0000, 16'h0000};
    vecs[6]  = '{0, 0,  2'b00, 16'h0000, 1, 7, 16'hAB34, 16'hAB34};
    vecs[7]  = '{1, 3,  2'b11, 16'h0011, 0, 0, 16'h0000, 16'h0000};
    vecs[8]  = '{1, 3,  2'b11, 16'h0022, 1, 3, 16'h0011, 16'h0022};
    vecs[9]  = '{0, 0,  2'b00, 16'h0000, 1, 3, 16'h0022, 16'h0022};
    vecs[10] = '{1, 5,  2'b01, 16'h99EE, 1, 5, 16'h0000, 16'h00EE};
    vecs[11] = '{0, 0,  2'b00, 16'h0000, 1, 5, 16'h00EE, 16'h00EE};
    vecs[12] = '{1, 6,  2'b00, 16'hFFFF, 0, 0, 16'h0000, 16'h0000};
    vecs[13] = '{0, 0,  2'b00, 16'h0000, 1, 6, 16'h0000, 16'h0000};
    vecs[14] = '{1, 4,  2'b11, 16'h4444, 1, 2, 16'h00AA, 16'h00AA};
    vecs[15] = '{0, 0,  2'b00, 16'h0000, 1, 4, 16'h4444, 16'h4444};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {14'd0, ready0, ready1}, 16'd0);
    chk("rst_valid", {14'd0, valid0, valid1}, 16'd0);
    chk("rst_data0", data0, 16'h0);
    chk("rst_data1", data1, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("init");
    for (int a = 0; a < 16; a++) read_chk(4'(a), 16'h0, 16'h0);

    // table of writes/reads
    foreach (vecs[k]) begin
      cyc(vecs[k].we, vecs[k].wa, vecs[k].be, vecs[k].wd, vecs[k].re, vecs[k].ra, 1'b0);
      chk($sformatf("v%0d_valid0", k), {15'd0, valid0}, {15'd0, vecs[k].re});
      if (vecs[k].re) chk($sformatf("v%0d_data0", k), data0, vecs[k].exp0);
      idle();
      chk($sformatf("v%0d_valid1", k), {15'd0, valid1}, {15'd0, vecs[k].re});
      if (vecs[k].re) chk($sformatf("v%0d_data1", k), data1, vecs[k].exp1);
    end

    // write at N then read at N+1, back-to-back read pulses
    cyc(1'b1, 4'd8, 2'b11, 16'hC0DE, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd8, 1'b0);
    chk("b2b_v0a", {15'd0, valid0}, 16'd1);
    chk("b2b_d0a", data0, 16'hC0DE);
    cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd7, 1'b0);
    chk("b2b_d0b", data0, 16'hAB34);
    chk("b2b_v1a", {15'd0, valid1}, 16'd1);
    chk("b2b_d1a", data1, 16'hC0DE);
    idle();
    chk("b2b_v0c", {15'd0, valid0}, 16'd0);
    chk("b2b_v1b", {15'd0, valid1}, 16'd1);
    chk("b2b_d1b", data1, 16'hAB34);
    idle();
    chk("b2b_v1c", {15'd0, valid1}, 16'd0);
    chk("hold_d1", data1, 16'hAB34);

    // fill, then clear with a read accepted on the clear edge
    for (int a = 0; a < 16; a++) cyc(1'b1, 4'(a), 2'b11, 16'hFFFF, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9, 1'b1);
    chk("clr_edge_v0", {15'd0, valid0}, 16'd1);
    chk("clr_edge_d0", data0, 16'hFFFF);
    chk("clr_edge_rdy", {14'd0, ready0, ready1}, 16'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 4'd0, 2'b11, 16'h7777, 1'b1, 4'd0, (i == 5));
      chk("clr_ready0", {15'd0, ready0}, (i == 16) ? 16'd1 : 16'd0);
      chk("clr_ready1", {15'd0, ready1}, (i == 16) ? 16'd1 : 16'd0);
      chk("clr_v0", {15'd0, valid0}, 16'd0);
      chk("clr_v1", {15'd0, valid1}, (i == 1) ? 16'd1 : 16'd0);
      if (i == 1) chk("clr_drain_d1", data1, 16'hFFFF);
    end
    idle();
    for (int a = 0; a < 16; a++) read_chk(4'(a), 16'h0, 16'h0);

    // reset with a read in flight in the 2-stage pipe
    cyc(1'b1, 4'd1, 2'b11, 16'h5A5A, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstrd_valid", {14'd0, valid0, valid1}, 16'd0);
    chk("rstrd_data1", data1, 16'h0);
    chk("rstrd_ready", {14'd0, ready0, ready1}, 16'd0);
    @(posedge clk);
    #1;
    chk("rstrd_v1_late", {15'd0, valid1}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("rst1");

    // reset in the middle of a clear
    cyc(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
    clear_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midclr_ready", {14'd0, ready0, ready1}, 16'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("rst2");
    read_chk(4'd1, 16'h0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
